tune_sequencer: RTL and testbench

Controller that plays a six-note tune through the speaker PWM path. On a start edge it snapshots six 8-bit note codes and a per-note duration, then steps through the notes in order. For each note it drives an enabled tone generator for the programmed number of clock cycles and inserts a fixed silent gap between notes. It pulses `done` when the tune ends. It sits between the game/control logic that supplies the notes and the audio output pin.

---
 rtl/tune_pkg.sv | 18 +
 rtl/tone_gen.sv | 36 +++
 rtl/tune_sequencer.sv | 142 ++++++++++++++
 tb/tb_tune_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tune_pkg.sv
// Shared types and sizing for the tune sequencer and its tone generator.
package tune_pkg;

  localparam int unsigned NUM_NOTES = 6;
  localparam int unsigned CODE_W    = 8;
  localparam int unsigned DUR_W     = 36;
  localparam int unsigned IDX_W     = 3;

  typedef logic [CODE_W-1:0] note_t;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap,
    StDone
  } state_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles pwm every halfPeriod cycles while enabled.
// A zero half-period is a rest and holds pwm low.
module tone_gen #(
  parameter int unsigned HpW = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clr,
  input  logic [HpW-1:0] halfPeriod,
  output logic           pwm
);

  logic [HpW-1:0] r_cnt;
  logic           r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else if (clr || (halfPeriod == '0)) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else if (en) begin
      if (r_cnt == halfPeriod - HpW'(1)) begin
        r_cnt <= '0;
        r_pwm <= ~r_pwm;
      end else begin
        r_cnt <= r_cnt + HpW'(1);
      end
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/tune_sequencer.sv
// Plays six latched note codes in order through a tone generator, with a fixed
// silent gap between notes and a one-cycle done pulse at the end of the tune.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int unsigned HP_SHIFT   = 4,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  note_t            sd0,
  input  note_t            sd1,
  input  note_t            sd2,
  input  note_t            sd3,
  input  note_t            sd4,
  input  note_t            sd5,
  input  logic [DUR_W-1:0] clockSpeed,
  output logic             pwm,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] noteIdx
);

  localparam int unsigned HpW  = CODE_W + HP_SHIFT;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_NOTES - 1);
  localparam logic [GapW-1:0]  GapLast = GapW'(GAP_CYCLES - 1);

  state_t           r_state;
  logic             r_start_q;
  logic             r_busy;
  logic             r_done;
  logic [IDX_W-1:0] r_note_idx;
  note_t            r_notes [NUM_NOTES];
  logic [DUR_W-1:0] r_dur;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [GapW-1:0]  r_gap_cnt;

  note_t            w_code;
  logic [HpW-1:0]   w_half;
  logic [DUR_W-1:0] w_dur_last;
  logic             w_trig;
  logic             w_note_end;
  logic             w_gap_end;
  logic             w_tone_en;
  logic             w_tone_clr;

  always_comb begin
    w_code = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (r_note_idx == IDX_W'(i)) w_code = r_notes[i];
    end
  end

  assign w_half     = HpW'(w_code) << HP_SHIFT;
  assign w_dur_last = (r_dur == '0) ? '0 : r_dur - DUR_W'(1);
  assign w_trig     = (r_state == StIdle) && start && !r_start_q;
  assign w_note_end = (r_state == StPlay) && (r_dur_cnt == w_dur_last);
  assign w_gap_end  = (r_state == StGap) && (r_gap_cnt == GapLast);

  // Clear the tone on the last cycle of a note so the gap starts silent and the
  // next note starts from a zeroed counter.
  assign w_tone_en  = (r_state == StPlay) && !w_note_end;
  assign w_tone_clr = !w_tone_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_start_q  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
      r_dur      <= '0;
      r_dur_cnt  <= '0;
      r_gap_cnt  <= '0;
      for (int i = 0; i < NUM_NOTES; i++) r_notes[i] <= '0;
    end else begin
      r_start_q <= start;
      r_done    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_trig) begin
            r_notes[0] <= sd0;
            r_notes[1] <= sd1;
            r_notes[2] <= sd2;
            r_notes[3] <= sd3;
            r_notes[4] <= sd4;
            r_notes[5] <= sd5;
            r_dur      <= clockSpeed;
            r_note_idx <= '0;
            r_dur_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= StPlay;
          end
        end
        StPlay: begin
          if (w_note_end) begin
            r_dur_cnt <= '0;
            if (r_note_idx == LastIdx) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= StGap;
            end
          end else begin
            r_dur_cnt <= r_dur_cnt + DUR_W'(1);
          end
        end
        StGap: begin
          if (w_gap_end) begin
            r_note_idx <= r_note_idx + IDX_W'(1);
            r_dur_cnt  <= '0;
            r_state    <= StPlay;
          end else begin
            r_gap_cnt <= r_gap_cnt + GapW'(1);
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  tone_gen #(
    .HpW(HpW)
  ) u_tone (
    .clk       (clk),
    .reset     (reset),
    .en        (w_tone_en),
    .clr       (w_tone_clr),
    .halfPeriod(w_half),
    .pwm       (pwm)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign noteIdx = r_note_idx;

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: per-cycle trace against a waveform built from the tune rules.
module tb_tune_sequencer;
  import tune_pkg::*;

  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  note_t       sd [6];
  logic [35:0] clock_speed;
  logic        pwm;
  logic        busy;
  logic        done;
  logic [2:0]  note_idx;

  int    total = 0;
  int    bad   = 0;
  note_t notes [6];

  always #5 clk = ~clk;

  tune_sequencer #(
    .HP_SHIFT  (0),
    .GAP_CYCLES(G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sd0       (sd[0]),
    .sd1       (sd[1]),
    .sd2       (sd[2]),
    .sd3       (sd[3]),
    .sd4       (sd[4]),
    .sd5       (sd[5]),
    .clockSpeed(clock_speed),
    .pwm       (pwm),
    .busy      (busy),
    .done      (done),
    .noteIdx   (note_idx)
  );

  task automatic check6(input string tag, input int t, input logic [5:0] obs,
                        input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d {busy,done,pwm,idx} observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Square wave of half-period c sampled k cycles into a note; c == 0 is silence.
  function automatic logic pwm_at(input note_t c, input int k);
    if (c == 0) return 1'b0;
    return 1'((k / int'(c)) % 2);
  endfunction

  task automatic rand_notes();
    for (int i = 0; i < 6; i++) notes[i] = note_t'($urandom_range(0, 12));
  endtask

  // Plays one tune; abort_at >= 0 asserts reset at that trace cycle instead of finishing.
  task automatic run_tune(input logic [35:0] d, input bit mess, input int abort_at,
                          output int busy_cnt, output int done_cnt);
    int         dd;
    logic [5:0] exp_q [$];
    dd       = (d == 0) ? 1 : int'(d[15:0]);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < dd; k++) exp_q.push_back({1'b1, 1'b0, pwm_at(notes[i], k), 3'(i)});
      if (i < 5) for (int g = 0; g < G; g++) exp_q.push_back({3'b100, 3'(i)});
    end
    exp_q.push_back(6'b010_101);
    repeat (3) exp_q.push_back(6'b000_101);

    @(negedge clk);
    for (int i = 0; i < 6; i++) sd[i] = notes[i];
    clock_speed = d;
    start       = 1'b1;
    @(posedge clk);
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge clk);
      check6("trace", t, {busy, done, pwm, note_idx}, exp_q[t]);
      busy_cnt += busy ? 1 : 0;
      done_cnt += done ? 1 : 0;
      if (t == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check6("reset_async", t, {busy, done, pwm, note_idx}, 6'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 3; w++) begin
          @(negedge clk);
          check6("post_reset_idle", w, {busy, done, pwm, note_idx}, 6'b0);
        end
        return;
      end
      if (mess) begin
        // Scramble inputs and re-edge start mid-tune, then hold start high to the end.
        if (t < exp_q.size() - 12) begin
          sd[1]       = note_t'($urandom);
          sd[3]       = note_t'($urandom);
          clock_speed = 36'($urandom);
          start       = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b1;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          bc;
    int          dc;
    logic [35:0] d;
    reset       = 1'b1;
    start       = 1'b0;
    clock_speed = '0;
    for (int i = 0; i < 6; i++) sd[i] = '0;
    repeat (2) @(negedge clk);
    check6("reset_state", 0, {busy, done, pwm, note_idx}, 6'b0);
    reset = 1'b0;
    @(negedge clk);

    notes = '{8'd5, 8'd10, 8'd8, 8'd15, 8'd5, 8'd5};
    run_tune(36'd20, 1'b0, -1, bc, dc);
    checki("busy_len_directed", bc, 130);
    checki("done_pulses_directed", dc, 1);

    rand_notes();
    notes[2] = 8'd0;
    run_tune(36'd20, 1'b0, -1, bc, dc);
    checki("busy_len_rest_slot2", bc, 130);

    rand_notes();
    run_tune(36'd0, 1'b0, -1, bc, dc);
    checki("busy_len_zero_dur", bc, 16);
    checki("done_pulses_zero_dur", dc, 1);

    rand_notes();
    notes[1] = 8'd3;
    run_tune(36'd15, 1'b1, -1, bc, dc);
    checki("busy_len_held_start", bc, 100);
    checki("done_pulses_held_start", dc, 1);
    repeat (4) @(negedge clk);
    check6("no_replay", 0, {busy, done, pwm, note_idx}, 6'b000_101);

    rand_notes();
    run_tune(36'd12, 1'b0, 3 * (12 + G) + 5, bc, dc);
    checki("aborted_no_done", dc, 0);
    run_tune(36'd12, 1'b0, -1, bc, dc);
    checki("busy_len_after_reset", bc, 82);

    for (int r = 0; r < 4; r++) begin
      d = 36'($urandom_range(0, 25));
      rand_notes();
      run_tune(d, 1'b0, -1, bc, dc);
      checki("busy_len_b2b", bc, 6 * ((d == 0) ? 1 : int'(d[15:0])) + 5 * G);
      checki("done_pulses_b2b", dc, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
